otter_cu_fsm: RTL and testbench

//  Multicycle control FSM for the OTTER core; sequences fetch/execute/memory/writeback around the combinational decoder.

---
 rtl/otter_cu_fsm_pkg.sv | 45 ++++
 rtl/otter_cu_fsm_if.sv | 35 +++
 rtl/otter_cu_fsm_wait_timer.sv | 35 +++
 rtl/otter_cu_fsm.sv | 175 +++++++++++++++++
 tb/tb_otter_cu_fsm.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_cu_fsm_pkg.sv
// Shared types for the OTTER multicycle control unit: FSM states, trap causes,
// RV32I major opcodes and the func3 value that separates mret from CSR ops.
package otter_cu_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } cu_state_t;

    // TC_NONE is what the port shows whenever csr_trap is low.
    typedef enum logic [1:0] {
        TC_NONE        = 2'd0,
        TC_INTR        = 2'd1,
        TC_ILLEGAL     = 2'd2,
        TC_BUS_TIMEOUT = 2'd3
    } trap_cause_t;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    localparam logic [2:0] FUNC3_PRIV   = 3'b000;
    localparam logic [2:0] FUNC3_CSRRW  = 3'b001;
    localparam logic [2:0] FUNC3_CSRRS  = 3'b010;
    localparam logic [2:0] FUNC3_CSRRC  = 3'b011;

    // Single-cycle instructions that retire with both a PC update and an rd write.
    function automatic logic is_rd_writer(input logic [6:0] op);
        return (op == OP_LUI)  || (op == OP_AUIPC) || (op == OP_IMM) ||
               (op == OP_REG)  || (op == OP_JAL)   || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control-unit bundle: decoded instruction fields, memory handshakes and
// interrupt inputs toward the CU, strobes and trap cause back to the datapath.
interface otter_cu_fsm_if;
    import otter_cu_fsm_pkg::*;

    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        intr;
    logic        mie;
    logic        imem_valid;
    logic        dmem_ready;

    logic        imem_rden;
    logic        dmem_rden;
    logic        dmem_we;
    logic        pc_we;
    logic        rf_we;
    logic        csr_we;
    logic        csr_trap;
    logic        csr_mret;
    trap_cause_t trap_cause;

    modport master (
        input  opcode, func3, intr, mie, imem_valid, dmem_ready,
        output imem_rden, dmem_rden, dmem_we, pc_we, rf_we,
               csr_we, csr_trap, csr_mret, trap_cause
    );

    modport slave (
        output opcode, func3, intr, mie, imem_valid, dmem_ready,
        input  imem_rden, dmem_rden, dmem_we, pc_we, rf_we,
               csr_we, csr_trap, csr_mret, trap_cause
    );

endinterface

// File: rtl/otter_cu_fsm_wait_timer.sv
// Access wait counter shared by FETCH and MEM; expired marks the last cycle an
// access may still complete before the FSM gives up on it.
module cu_wait_timer #(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int            W    = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [W-1:0]  LAST = W'(WAIT_TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control FSM: fetch/exec/mem/writeback sequencing with
// handshaked memories, access timeouts, interrupt entry, illegal-op trap, CSR and mret.
module otter_cu_fsm
    import otter_cu_fsm_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16,
    parameter bit EN_INTR      = 1'b1,
    parameter bit EN_ILL_TRAP  = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    otter_cu_fsm_if.master bus
);

    cu_state_t   state_q, state_d;
    trap_cause_t cause_q, cause_d;
    logic        is_store_q, is_store_d;

    logic tmr_clr, tmr_inc, tmr_expired;

    logic        imem_rden, dmem_rden, dmem_we;
    logic        pc_we, rf_we, csr_we, csr_trap, csr_mret;
    trap_cause_t trap_cause;

    cu_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            cause_q    <= TC_NONE;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            is_store_q <= is_store_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        is_store_d = is_store_q;
        tmr_inc    = 1'b0;
        imem_rden  = 1'b0;
        dmem_rden  = 1'b0;
        dmem_we    = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        csr_we     = 1'b0;
        csr_trap   = 1'b0;
        csr_mret   = 1'b0;
        trap_cause = TC_NONE;

        unique case (state_q)
            ST_FETCH: begin
                imem_rden = 1'b1;
                if (bus.imem_valid) begin
                    state_d = ST_EXEC;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TC_BUS_TIMEOUT;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            ST_EXEC: begin
                // A pending interrupt preempts the fetched instruction entirely.
                if (EN_INTR && bus.intr && bus.mie) begin
                    state_d = ST_TRAP;
                    cause_d = TC_INTR;
                end else if (bus.opcode == OP_LOAD) begin
                    state_d    = ST_MEM;
                    is_store_d = 1'b0;
                end else if (bus.opcode == OP_STORE) begin
                    state_d    = ST_MEM;
                    is_store_d = 1'b1;
                end else if (is_rd_writer(bus.opcode)) begin
                    pc_we   = 1'b1;
                    rf_we   = 1'b1;
                    state_d = ST_FETCH;
                end else if (bus.opcode == OP_BRANCH) begin
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                end else if (bus.opcode == OP_SYSTEM) begin
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                    if (bus.func3 == FUNC3_PRIV) begin
                        csr_mret = 1'b1;
                    end else begin
                        csr_we = 1'b1;
                        rf_we  = 1'b1;
                    end
                end else if (EN_ILL_TRAP) begin
                    state_d = ST_TRAP;
                    cause_d = TC_ILLEGAL;
                end else begin
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_MEM: begin
                // Direction comes from the latch; opcode is no longer stable here.
                dmem_rden = !is_store_q;
                dmem_we   = is_store_q;
                if (bus.dmem_ready) begin
                    if (is_store_q) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TC_BUS_TIMEOUT;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            ST_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = ST_FETCH;
            end

            ST_TRAP: begin
                csr_trap   = 1'b1;
                pc_we      = 1'b1;
                trap_cause = cause_q;
                state_d    = ST_FETCH;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // State already sits at ST_FETCH under reset; this keeps imem_rden quiet too.
        if (rst) begin
            imem_rden  = 1'b0;
            dmem_rden  = 1'b0;
            dmem_we    = 1'b0;
            pc_we      = 1'b0;
            rf_we      = 1'b0;
            csr_we     = 1'b0;
            csr_trap   = 1'b0;
            csr_mret   = 1'b0;
            trap_cause = TC_NONE;
        end
    end

    assign tmr_clr = (state_d != state_q);

    assign bus.imem_rden  = imem_rden;
    assign bus.dmem_rden  = dmem_rden;
    assign bus.dmem_we    = dmem_we;
    assign bus.pc_we      = pc_we;
    assign bus.rf_we      = rf_we;
    assign bus.csr_we     = csr_we;
    assign bus.csr_trap   = csr_trap;
    assign bus.csr_mret   = csr_mret;
    assign bus.trap_cause = trap_cause;

    a_dmem_excl: assert property (@(posedge clk) disable iff (rst) !(dmem_rden && dmem_we));
    a_pc_src:    assert property (@(posedge clk) disable iff (rst) !(csr_trap && csr_mret));

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Bench for otter_cu_fsm: builds per-cycle expected strobe traces from instruction
// scenarios (latency rules) and compares two differently configured DUTs every cycle.
module tb_otter_cu_fsm;
    import otter_cu_fsm_pkg::*;

    localparam int WT = 4;

    localparam logic [9:0] E_IMEM  = 10'h200;
    localparam logic [9:0] E_DRD   = 10'h100;
    localparam logic [9:0] E_DWE   = 10'h080;
    localparam logic [9:0] E_PC    = 10'h040;
    localparam logic [9:0] E_RF    = 10'h020;
    localparam logic [9:0] E_CSRWE = 10'h010;
    localparam logic [9:0] E_TRAP  = 10'h008;
    localparam logic [9:0] E_MRET  = 10'h004;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       intr;
        logic       mie;
        logic       iv;
        logic       dr;
        logic [9:0] exp;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic intr, mie, iv, dr;

    int n_checks = 0;
    int n_err    = 0;

    cyc_t q[$];
    logic       cmp_on  = 1'b0;
    logic       cur_sel = 1'b0;
    logic [9:0] cur_exp = '0;

    always #5 clk = ~clk;

    otter_cu_fsm_if bus_a ();
    otter_cu_fsm_if bus_b ();

    assign bus_a.opcode = opcode;  assign bus_b.opcode = opcode;
    assign bus_a.func3 = func3;    assign bus_b.func3 = func3;
    assign bus_a.intr = intr;      assign bus_b.intr = intr;
    assign bus_a.mie = mie;        assign bus_b.mie = mie;
    assign bus_a.imem_valid = iv;  assign bus_b.imem_valid = iv;
    assign bus_a.dmem_ready = dr;  assign bus_b.dmem_ready = dr;

    otter_cu_fsm #(.WAIT_TIMEOUT(WT), .EN_INTR(1'b1), .EN_ILL_TRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a.master));

    otter_cu_fsm #(.WAIT_TIMEOUT(WT), .EN_INTR(1'b0), .EN_ILL_TRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b.master));

    logic [9:0] out_a, out_b;
    assign out_a = {bus_a.imem_rden, bus_a.dmem_rden, bus_a.dmem_we, bus_a.pc_we, bus_a.rf_we,
                    bus_a.csr_we, bus_a.csr_trap, bus_a.csr_mret, bus_a.trap_cause};
    assign out_b = {bus_b.imem_rden, bus_b.dmem_rden, bus_b.dmem_we, bus_b.pc_we, bus_b.rf_we,
                    bus_b.csr_we, bus_b.csr_trap, bus_b.csr_mret, bus_b.trap_cause};

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] trap_v(input logic [1:0] cause);
        return E_TRAP | E_PC | {8'd0, cause};
    endfunction

    // Expected trace for one instruction: fw fetch waits, mw memory waits.
    // Off-state inputs carry stray valid/ready/interrupt levels that must be ignored.
    task automatic gen(input logic [6:0] op, input logic [2:0] f3, input logic intr_e,
                       input logic mie_e, input int fw, input int mw,
                       input bit en_intr, input bit en_ill);
        cyc_t c;
        bit   st;
        c.op = 7'h00; c.f3 = 3'd0; c.intr = 1'b1; c.mie = 1'b1; c.dr = 1'b1; c.iv = 1'b0;
        c.exp = E_IMEM;
        for (int i = 0; i < fw && i < WT; i++) q.push_back(c);
        if (fw >= WT) begin
            c.exp = trap_v(TC_BUS_TIMEOUT); q.push_back(c); return;
        end
        c.iv = 1'b1; q.push_back(c);

        c.op = op; c.f3 = f3; c.intr = intr_e; c.mie = mie_e;
        if (en_intr && intr_e && mie_e) begin
            c.exp = '0; q.push_back(c);
            c.exp = trap_v(TC_INTR); q.push_back(c); return;
        end
        if (op == OP_LOAD || op == OP_STORE) begin
            st = (op == OP_STORE);
            c.exp = '0; q.push_back(c);
            c.op = st ? OP_LOAD : OP_STORE; c.intr = 1'b1; c.mie = 1'b1; c.dr = 1'b0;
            c.exp = st ? E_DWE : E_DRD;
            for (int j = 0; j < mw && j < WT; j++) q.push_back(c);
            if (mw >= WT) begin
                c.exp = trap_v(TC_BUS_TIMEOUT); q.push_back(c); return;
            end
            c.dr = 1'b1;
            c.exp = st ? (E_DWE | E_PC) : E_DRD; q.push_back(c);
            if (!st) begin c.exp = E_RF | E_PC; q.push_back(c); end
            return;
        end
        case (op)
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_JAL, OP_JALR: c.exp = E_PC | E_RF;
            OP_BRANCH: c.exp = E_PC;
            OP_SYSTEM: c.exp = (f3 == FUNC3_PRIV) ? (E_PC | E_MRET) : (E_PC | E_RF | E_CSRWE);
            default: begin
                if (en_ill) begin
                    c.exp = '0; q.push_back(c);
                    c.exp = trap_v(TC_ILLEGAL);
                end else begin
                    c.exp = E_PC;
                end
            end
        endcase
        q.push_back(c);
    endtask

    // Replays the queued trace on the selected DUT; the other stays in reset.
    task automatic run(input bit sel_b);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            opcode = c.op; func3 = c.f3; intr = c.intr; mie = c.mie; iv = c.iv; dr = c.dr;
            if (sel_b) rst_b = 1'b0; else rst_a = 1'b0;
            cur_exp = c.exp; cur_sel = sel_b; cmp_on = 1'b1;
        end
        #3;
    endtask

    always @(negedge clk) begin
        #2;
        if (cmp_on) begin
            check("trace_a", out_a, cur_sel ? 10'h000 : cur_exp);
            check("trace_b", out_b, cur_sel ? cur_exp : 10'h000);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        opcode = OP_LOAD; func3 = 3'd0; intr = 1'b1; mie = 1'b1; iv = 1'b1; dr = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("reset_a", out_a, 10'h000);
        check("reset_b", out_b, 10'h000);

        // ---- dut_a: WAIT_TIMEOUT=4, interrupts and illegal trap enabled ----
        gen(OP_IMM, 3'd0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        check("pin_opimm_len", 10'(q.size()), 10'd2);
        check("pin_opimm_c2", q[1].exp, 10'h060);
        run(1'b0);

        gen(OP_LOAD, 3'd2, 1'b0, 1'b0, 0, 3, 1'b1, 1'b1);
        check("pin_load_len", 10'(q.size()), 10'd7);
        check("pin_load_rdy", q[5].exp, 10'h100);
        check("pin_load_wb", q[6].exp, 10'h060);
        run(1'b0);

        gen(OP_STORE, 3'd2, 1'b0, 1'b0, 0, 99, 1'b1, 1'b1);
        check("pin_st_to_len", 10'(q.size()), 10'd7);
        check("pin_st_to_trap", q[6].exp, 10'h04B);
        run(1'b0);

        gen(OP_STORE, 3'd2, 1'b1, 1'b1, 1, 0, 1'b1, 1'b1);
        check("pin_intr_trap", q[3].exp, 10'h049);
        run(1'b0);

        gen(OP_STORE, 3'd2, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1);
        check("pin_st_nomie", q[2].exp, 10'h0C0);
        run(1'b0);

        gen(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        check("pin_ill_trap", q[2].exp, 10'h04A);
        run(1'b0);

        gen(OP_SYSTEM, FUNC3_PRIV, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        check("pin_mret", q[1].exp, 10'h044);
        run(1'b0);

        gen(OP_SYSTEM, FUNC3_CSRRS, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        run(1'b0);
        gen(OP_BRANCH, 3'd1, 1'b0, 1'b0, 2, 0, 1'b1, 1'b1);
        run(1'b0);
        gen(OP_JAL, 3'd0, 1'b0, 1'b0, 4, 0, 1'b1, 1'b1);
        check("pin_fetch_to", q[4].exp, 10'h04B);
        run(1'b0);
        gen(OP_LUI, 3'd0, 1'b0, 1'b0, 3, 0, 1'b1, 1'b1);
        run(1'b0);
        gen(OP_LOAD, 3'd0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        run(1'b0);
        gen(OP_JALR, 3'd0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        run(1'b0);

        // ---- reset in the middle of a load's memory wait ----
        @(negedge clk);
        cmp_on = 1'b0; opcode = 7'h00; iv = 1'b1; dr = 1'b0; intr = 1'b0; mie = 1'b0;
        @(negedge clk);
        opcode = OP_LOAD; iv = 1'b0;
        @(negedge clk);
        opcode = OP_STORE;
        #2 check("rst_mem1", out_a, E_DRD);
        @(negedge clk);
        #2 check("rst_mem2", out_a, E_DRD);
        rst_a = 1'b1;
        #1 check("rst_async", out_a, 10'h000);
        @(negedge clk);
        #1 check("rst_hold", out_a, 10'h000);
        rst_a = 1'b0;
        #1 check("rst_release", out_a, E_IMEM);
        rst_a = 1'b1;
        #1 check("rst_reassert", out_a, 10'h000);

        // ---- dut_b: interrupts ignored, unknown opcodes retire as NOPs ----
        gen(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        check("pin_ill_nop_len", 10'(q.size()), 10'd2);
        check("pin_ill_nop", q[1].exp, 10'h040);
        run(1'b1);
        gen(OP_STORE, 3'd2, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0);
        run(1'b1);
        gen(OP_AUIPC, 3'd0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0);
        run(1'b1);
        gen(OP_LOAD, 3'd0, 1'b0, 1'b0, 0, 4, 1'b0, 1'b0);
        run(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
